power_uart_rx: RTL and testbench
================================

// Module: power_uart_rx
// PURPOSE
//  RS232 byte receiver for the customer power-amplifier control link, 8N1, LSB first.
//  Sits directly upstream of the PA command frame decoder (C0/LEN/data/checksum/CF).
//  Drives that decoder's rx_ready/rx_data pair: one rx_ready falling edge per good byte.
//  Oversamples uart_rxd with a 3-sample majority vote at mid-bit and rejects false starts.
//  Bytes with a bad stop bit are dropped and counted.
// PARAMETERS
//  CLKS_PER_BIT  16  clk cycles per UART bit (clk/baud). Must be >= 8. HALF = CLKS_PER_BIT/2.
//  SYNC_STAGES   2   metastability flops on uart_rxd. Must be >= 2.
// PORTS
//  clk          in   1  system clock
//  rst_n        in   1  reset: asynchronous, active-low
//  uart_rxd     in   1  asynchronous serial line, idle high
//  rx_ready     out  1  high while a byte is being received. Falling edge = new rx_data.
//  rx_data      out  8  last good byte. Held until the next good byte.
//  rx_byte_vld  out  1  1-cycle pulse, coincident with the rx_ready falling edge
//  rx_err       out  1  1-cycle pulse on a framing error (stop bit sampled 0)
//  rx_err_cnt   out  8  framing-error count, saturates at 8'hFF
// BEHAVIOUR
//  Reset values: rx_ready=0, rx_data=8'h00, rx_byte_vld=0, rx_err=0, rx_err_cnt=0.
//   Sync flops reset to 1. FSM resets to IDLE.
//  rxs is the synchronised line. baud_cnt runs 0..CLKS_PER_BIT-1 within each bit period.
//  Sample point: the bit value is the majority of rxs at baud_cnt HALF-1, HALF and HALF+1.
//   It is registered at HALF+1.
//  FSM states:
//   IDLE: on a rxs 1->0 edge, go to START with baud_cnt=0.
//   START: at the sample point:
//    - majority 1 -> false start. Return to IDLE. No output changes.
//    - majority 0 -> rx_ready<=1 (if not already 1). Clear bit_idx. Go to DATA.
//   DATA: at each sample point, shift the bit into shift_reg[bit_idx] (LSB first).
//    - After bit 7, go to STOP.
//    - baud_cnt wraps CLKS_PER_BIT-1 -> 0 with no slip; each bit is CLKS_PER_BIT clks.
//   STOP: at the sample point:
//    - majority 1 -> next cycle rx_data<=shift_reg, rx_ready<=0, rx_byte_vld=1. Go to IDLE.
//    - majority 0 -> rx_err=1 and rx_err_cnt++ (saturating). rx_data unchanged.
//      rx_ready stays 1. Go to BREAK.
//   BREAK: wait until rxs==1, then go to IDLE.
//  A start edge is accepted in IDLE from the cycle after the STOP decision.
//   So back-to-back bytes with zero idle time are supported.
//  After a framing error, rx_ready stays high through the next byte(s).
//   It falls only when a good byte completes.
//   So the decoder never samples stale or bad data on an edge.
//  rx_ready never falls without rx_data being updated in the same cycle.
//  Glitches on rxs shorter than HALF-1 clks in IDLE are rejected by the START check.
//   A single-clk glitch at a sample point is outvoted.
//  rst_n asserted mid-byte: immediate return to reset values. The partial byte is discarded.
//   Reception resumes on the next start edge after release.
//  Latency: good stop sample (HALF+1 into the stop bit) -> rx_ready low one clk later.
//   Plus SYNC_STAGES clks from uart_rxd.
// TESTING (CLKS_PER_BIT=16, 1 bit = 16 clk)
//  1. Send 0xC0, then idle
//     -> rx_ready rises once, then falls once; rx_data=8'hC0; rx_byte_vld one pulse; rx_err=0.
//  2. Back-to-back C0 05 11 22 33 44 AA CF with zero idle between frames
//     -> 8 falling edges, rx_data in exact order; decoder instance outputs recirve_vld.
//  3. 4-clk low pulse on idle line
//     -> rx_ready stays 0, FSM returns to IDLE, rx_data unchanged.
//  4. Byte 0x55 with stop bit 0, line high 20 clks, then 0xCF
//     -> rx_err pulse, rx_err_cnt=1, rx_ready held high;
//        then a single fall with rx_data=8'hCF.
//  5. Byte 0xA5 with a 1-clk inverted glitch at HALF of bit 3
//     -> rx_data=8'hA5, rx_err=0.
//  6. rst_n low during bit 4 of 0x3C, released, then send 0x3C
//     -> all outputs at reset values during reset; rx_data=8'h3C afterwards.
//  7. 300 framing errors -> rx_err_cnt saturates at 8'hFF.

Source files
------------

// File: rtl/power_uart_rx.sv
// power_uart_rx: 8N1 LSB-first UART byte receiver for the PA control link.
// 3-sample mid-bit majority vote, false-start rejection, framing-error count.
//
// Ports:
//   clk         in   system clock
//   rst_n       in   asynchronous active-low reset
//   uart_rxd    in   asynchronous serial line, idle high
//   rx_ready    out  high while a byte is in flight; falling edge = new rx_data
//   rx_data     out  last good byte, held until the next good byte
//   rx_byte_vld out  1-clk pulse coincident with the rx_ready falling edge
//   rx_err      out  1-clk pulse when a stop bit is sampled low
//   rx_err_cnt  out  saturating framing-error count

module power_uart_rx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int SYNC_STAGES  = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       uart_rxd,
  output logic       rx_ready,
  output logic [7:0] rx_data,
  output logic       rx_byte_vld,
  output logic       rx_err,
  output logic [7:0] rx_err_cnt
);

  localparam int HALF = CLKS_PER_BIT / 2;
  localparam int CW   = $clog2(CLKS_PER_BIT);

  localparam logic [CW-1:0] SMP0 = CW'(HALF - 1);
  localparam logic [CW-1:0] SMP1 = CW'(HALF);
  localparam logic [CW-1:0] SMP2 = CW'(HALF + 1);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_e;

  state_e state_q, state_d;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rxs;
  logic                   rxs_prev_q;

  logic [CW-1:0] baud_q, baud_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q, shift_d;
  logic [1:0]    smp_q;
  logic          maj;
  logic          at_smp;

  logic       ready_q, ready_d;
  logic [7:0] data_q, data_d;
  logic       vld_q, vld_d;
  logic       err_q, err_d;
  logic [7:0] errcnt_q, errcnt_d;

  assign rxs = sync_q[SYNC_STAGES-1];

  // Line idles high, so the synchroniser and edge history
  // reset to 1 to avoid a phantom start edge out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q     <= '1;
      rxs_prev_q <= 1'b1;
    end else begin
      sync_q     <= {sync_q[SYNC_STAGES-2:0], uart_rxd};
      rxs_prev_q <= rxs;
    end
  end

  // First two votes are captured; the third is the live rxs
  // at HALF+1, where the decision is made.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      smp_q <= 2'b11;
    end else begin
      if (baud_q == SMP0) smp_q[0] <= rxs;
      if (baud_q == SMP1) smp_q[1] <= rxs;
    end
  end

  assign maj = (smp_q[0] & smp_q[1]) |
               (smp_q[0] & rxs) |
               (smp_q[1] & rxs);

  assign at_smp = (baud_q == SMP2);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      baud_q    <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      ready_q   <= 1'b0;
      data_q    <= '0;
      vld_q     <= 1'b0;
      err_q     <= 1'b0;
      errcnt_q  <= '0;
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      ready_q   <= ready_d;
      data_q    <= data_d;
      vld_q     <= vld_d;
      err_q     <= err_d;
      errcnt_q  <= errcnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    baud_d    = (baud_q == LAST) ? '0
                                 : baud_q + CW'(1);
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    ready_d   = ready_q;
    data_d    = data_q;
    vld_d     = 1'b0;
    err_d     = 1'b0;
    errcnt_d  = errcnt_q;

    unique case (state_q)
      S_IDLE: begin
        baud_d = '0;
        if (rxs_prev_q && !rxs) begin
          state_d = S_START;
        end
      end

      S_START: begin
        if (at_smp) begin
          if (maj) begin
            state_d = S_IDLE;
          end else begin
            ready_d   = 1'b1;
            bit_idx_d = '0;
            state_d   = S_DATA;
          end
        end
      end

      // baud_q keeps free-running across bits so
      // every bit is exactly CLKS_PER_BIT clocks.
      S_DATA: begin
        if (at_smp) begin
          shift_d[bit_idx_q] = maj;
          if (bit_idx_q == 3'd7) begin
            state_d = S_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end

      S_STOP: begin
        if (at_smp) begin
          if (maj) begin
            data_d  = shift_q;
            ready_d = 1'b0;
            vld_d   = 1'b1;
            state_d = S_IDLE;
          end else begin
            // rx_ready stays high so the decoder
            // never latches the bad byte.
            err_d = 1'b1;
            if (errcnt_q != 8'hFF) begin
              errcnt_d = errcnt_q + 8'd1;
            end
            state_d = S_BREAK;
          end
        end
      end

      S_BREAK: begin
        baud_d = '0;
        if (rxs) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign rx_ready    = ready_q;
  assign rx_data     = data_q;
  assign rx_byte_vld = vld_q;
  assign rx_err      = err_q;
  assign rx_err_cnt  = errcnt_q;

endmodule

// File: tb/tb_power_uart_rx.sv
// tb_power_uart_rx: directed table + randomized frames against a
// byte-queue / saturating-counter model of the receiver.

module tb_power_uart_rx;

  localparam int CPB = 16;

  logic       clk;
  logic       rst_n;
  logic       uart_rxd;
  logic       rx_ready;
  logic [7:0] rx_data;
  logic       rx_byte_vld;
  logic       rx_err;
  logic [7:0] rx_err_cnt;

  power_uart_rx #(
    .CLKS_PER_BIT(CPB),
    .SYNC_STAGES (2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .uart_rxd   (uart_rxd),
    .rx_ready   (rx_ready),
    .rx_data    (rx_data),
    .rx_byte_vld(rx_byte_vld),
    .rx_err     (rx_err),
    .rx_err_cnt (rx_err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nvec = 0;
  int nmis = 0;

  int rises = 0;
  int falls = 0;
  int errp  = 0;
  logic prev_ready = 1'b0;
  bit sb_en = 1'b0;
  logic [7:0] expq[$];

  int errm = 0;
  logic [7:0] last_good = 8'h00;

  typedef struct {
    logic [7:0] data;
    bit         stop_ok;
    int         gbit;
    int         idle;
    logic [7:0] exp_data;
    int         exp_rises;
    int         exp_falls;
    int         exp_errs;
    bit         exp_ready;
  } vec_t;

  vec_t tbl[12];
  logic [7:0] b2b[8];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  function automatic int sat(input int v);
    return (v >= 255) ? 255 : v + 1;
  endfunction

  task automatic idle(input int n);
    uart_rxd = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d,
                            input bit stop_ok,
                            input int gbit,
                            input int goff);
    uart_rxd = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      for (int c = 0; c < CPB; c++) begin
        uart_rxd = (gbit == i && c == goff) ? ~d[i] : d[i];
        @(negedge clk);
      end
    end
    uart_rxd = stop_ok;
    repeat (CPB) @(negedge clk);
  endtask

  // Monitor: edge counters, ready/vld coupling, scoreboard.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_ready <= 1'b0;
    end else begin
      if (!prev_ready && rx_ready) rises <= rises + 1;
      if (prev_ready && !rx_ready) falls <= falls + 1;
      if ((prev_ready && !rx_ready) || rx_byte_vld)
        chk("ready_fall_vld",
            {29'd0, prev_ready, rx_ready, rx_byte_vld},
            32'd5);
      if (rx_err) errp <= errp + 1;
      if (rx_byte_vld && sb_en) begin
        if (expq.size() == 0) begin
          nvec++;
          nmis++;
          $display("FAIL sb_extra: got %0h expected none",
                   rx_data);
        end else begin
          chk("sb_data", 32'(rx_data),
              32'(expq.pop_front()));
        end
      end
      prev_ready <= rx_ready;
    end
  end

  initial begin
    int r0, f0, e0, gb, go, gap;
    logic [7:0] d;
    bit ok;

    rst_n    = 1'b0;
    uart_rxd = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(rx_ready), 32'd0);
    chk("rst_data", 32'(rx_data), 32'd0);
    chk("rst_vld", 32'(rx_byte_vld), 32'd0);
    chk("rst_err", 32'(rx_err), 32'd0);
    chk("rst_errcnt", 32'(rx_err_cnt), 32'd0);
    rst_n = 1'b1;
    idle(10);

    b2b = '{8'hC0, 8'h05, 8'h11, 8'h22,
            8'h33, 8'h44, 8'hAA, 8'hCF};
    tbl[0] = '{8'hC0, 1'b1, -1, 20, 8'hC0, 1, 1, 0, 1'b0};
    for (int i = 0; i < 8; i++)
      tbl[1+i] = '{b2b[i], 1'b1, -1, (i == 7) ? 10 : 0,
                   b2b[i], 1, 1, 0, 1'b0};
    tbl[9]  = '{8'h55, 1'b0, -1, 20, 8'hCF, 1, 0, 1, 1'b1};
    tbl[10] = '{8'hCF, 1'b1, -1, 10, 8'hCF, 0, 1, 0, 1'b0};
    tbl[11] = '{8'hA5, 1'b1, 3, 10, 8'hA5, 1, 1, 0, 1'b0};

    for (int i = 0; i < 12; i++) begin
      r0 = rises;
      f0 = falls;
      e0 = errp;
      send_frame(tbl[i].data, tbl[i].stop_ok,
                 tbl[i].gbit, CPB / 2);
      if (!tbl[i].stop_ok) errm = sat(errm);
      chk("tbl_data", 32'(rx_data), 32'(tbl[i].exp_data));
      chk("tbl_rises", rises - r0, tbl[i].exp_rises);
      chk("tbl_falls", falls - f0, tbl[i].exp_falls);
      chk("tbl_errs", errp - e0, tbl[i].exp_errs);
      chk("tbl_ready", 32'(rx_ready), 32'(tbl[i].exp_ready));
      chk("tbl_errcnt", 32'(rx_err_cnt), errm);
      idle(tbl[i].idle);
    end
    last_good = 8'hA5;

    // 4-clk low pulse on an idle line: false start.
    r0 = rises;
    e0 = errp;
    uart_rxd = 1'b0;
    repeat (4) @(negedge clk);
    idle(40);
    chk("glitch_rises", rises - r0, 0);
    chk("glitch_errs", errp - e0, 0);
    chk("glitch_ready", 32'(rx_ready), 32'd0);
    chk("glitch_data", 32'(rx_data), 32'(last_good));

    // Reset during bit 4 of 0x3C.
    d = 8'h3C;
    uart_rxd = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      uart_rxd = d[i];
      repeat (CPB) @(negedge clk);
    end
    uart_rxd = d[4];
    repeat (CPB / 2) @(negedge clk);
    chk("pre_rst_ready", 32'(rx_ready), 32'd1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_ready", 32'(rx_ready), 32'd0);
    chk("mid_rst_data", 32'(rx_data), 32'd0);
    chk("mid_rst_vld", 32'(rx_byte_vld), 32'd0);
    chk("mid_rst_err", 32'(rx_err), 32'd0);
    chk("mid_rst_errcnt", 32'(rx_err_cnt), 32'd0);
    idle(5);
    rst_n = 1'b1;
    errm = 0;
    idle(10);
    f0 = falls;
    send_frame(8'h3C, 1'b1, -1, 0);
    idle(5);
    chk("post_rst_data", 32'(rx_data), 32'h3C);
    chk("post_rst_falls", falls - f0, 1);
    last_good = 8'h3C;

    // Framing-error saturation.
    e0 = errp;
    for (int i = 0; i < 300; i++) begin
      send_frame(8'($urandom), 1'b0, -1, 0);
      errm = sat(errm);
      idle(4);
      if (i == 9)
        chk("sat_cnt10", 32'(rx_err_cnt), errm);
    end
    chk("sat_cnt", 32'(rx_err_cnt), 32'hFF);
    chk("sat_pulses", errp - e0, 300);
    chk("sat_ready", 32'(rx_ready), 32'd1);
    chk("sat_data", 32'(rx_data), 32'(last_good));

    // Randomized frames against the byte-queue model.
    expq.delete();
    sb_en = 1'b1;
    for (int i = 0; i < 40; i++) begin
      d  = 8'($urandom);
      ok = ($urandom_range(0, 9) != 0);
      gb = ($urandom_range(0, 3) == 0) ?
           int'($urandom_range(0, 7)) : -1;
      go = int'($urandom_range(8, 10));
      if (ok) expq.push_back(d);
      else errm = sat(errm);
      send_frame(d, ok, gb, go);
      if (ok) last_good = d;
      gap = ok ? int'($urandom_range(0, 12))
               : int'($urandom_range(4, 20));
      idle(gap);
    end
    idle(40);
    chk("rand_pending", expq.size(), 0);
    chk("rand_errcnt", 32'(rx_err_cnt), errm);
    chk("rand_data", 32'(rx_data), 32'(last_good));
    sb_en = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nmis);
    $finish;
  end

endmodule
